i2c_bit_engine: RTL and testbench
=================================

Name: i2c_bit_engine

Overview:
- Parametrised successor to the single-phase I2C start logic: a complete bit-level I2C master engine.
- Executes START, repeated START, STOP, WRITE-bit and READ-bit commands as sequences of timed half-period phases.
- Supports clock stretching, arbitration-loss detection and illegal-command rejection.
- Sits between the byte-level I2C controller (command/response side) and the open-drain pad drivers (scl/sda side).

Parameters:
- CTR_WIDTH, 16: width of the phase counter and of dbl_clock_divisor.
- STRETCH_EN, 1: 1 = phase counter freezes while scl is released but scl_in is low.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dbl_clock_divisor  in  CTR_WIDTH  phase length minus 1 (D); latched on command accept
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine can accept a command
- cmd_op  in  3  0=START 1=RSTART 2=STOP 3=WRITE 4=READ; 5-7 illegal
- cmd_bit  in  1  data bit for WRITE
- rsp_valid  out  1  one-cycle pulse: command complete
- rsp_bit  out  1  sampled sda_in for READ/WRITE; 0 otherwise
- rsp_arb_lost  out  1  qualifies rsp_valid: arbitration lost
- cmd_error  out  1  one-cycle pulse: illegal command rejected
- bus_active  out  1  engine owns the bus (between START and STOP)
- scl_in  in  1  synchronised SCL line state
- sda_in  in  1  synchronised SDA line state
- scl_out  out  1  0 = drive SCL low, 1 = release
- sda_out  out  1  0 = drive SDA low, 1 = release

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-command):
  - scl_out=1, sda_out=1, cmd_ready=1, bus_active=0.
  - rsp_valid=0, rsp_bit=0, rsp_arb_lost=0, cmd_error=0.
  - State k_idle, ctr=0.
- Phase timing:
  - Every phase lasts D+1 cycles. ctr runs 0..D; at ctr==D the state advances and ctr is cleared to 0, otherwise ctr increments.
  - D=0 gives 1-cycle phases. D is latched at accept, so a change during a command has no effect.
- Clock stretching: in phases with scl_out=1, when STRETCH_EN=1 and scl_in=0, ctr holds and the phase does not end.
- Resting states:
  - k_idle: bus free; scl_out=1, sda_out=1.
  - k_hold: bus owned; scl_out=0, sda_out keeps its last value.
  - cmd_ready=1 only in these two states.
- Accept: cmd_valid && cmd_ready on cycle T. The first phase's outputs appear registered at T+1.
- Legality:
  - START is legal only in k_idle.
  - RSTART, STOP, WRITE and READ are legal only in k_hold.
  - An illegal or unknown op gives cmd_error=1 at T+1, no state change, no rsp_valid.
- Phase sequences (scl_out, sda_out):
  - START: k_start1(1,0), k_start2(0,0) -> k_hold; bus_active=1.
  - RSTART: k_rs1(0,1), k_rs2(1,1), then k_start1, k_start2 -> k_hold.
  - STOP: k_sp1(0,0), k_sp2(1,0), k_sp3(1,1) -> k_idle; bus_active=0.
  - WRITE b: k_wb1(0,b), k_wb2(1,b). sda_in is sampled on the last cycle of k_wb2 -> k_hold.
  - READ: k_rb1(0,1), k_rb2(1,1). sda_in is sampled on the last cycle of k_rb2 -> k_hold.
- Completion:
  - rsp_valid=1 on the first cycle back in the resting state; cmd_ready=1 on that same cycle, so back-to-back accept is allowed.
  - rsp_bit is the sampled sda_in.
- Arbitration:
  - Arbitration is lost when WRITE b=1 samples sda_in=0, or when sda_in=0 on the last cycle of k_sp3.
  - On loss: rsp_valid=1 with rsp_arb_lost=1, state goes to k_idle, scl_out=1, sda_out=1, bus_active=0.
- rsp_valid and cmd_error are never asserted together.

Decomposition:
- Shared package (include/i2c.vh), extended:
  - state constants k_idle, k_hold, k_start1, k_start2, k_rs1, k_rs2, k_sp1..k_sp3, k_wb1, k_wb2, k_rb1, k_rb2 (4-bit);
  - op codes k_op_start..k_op_read.
- One sub-module, i2c_phase_timer:
  - owns ctr, the latched divisor and the stretch freeze;
  - emits phase_done.

Test Plan:
- D=3, START from idle at T: sda_out=0 over T+1..T+8, scl_out=0 from T+5, rsp_valid at T+9, bus_active=1.
- D=3, WRITE 1 with sda_in=1, then READ with sda_in=0: both responses arrive 8 cycles after accept; rsp_bit=1 then 0; no arb_lost.
- D=1, WRITE with scl_in held low for 5 cycles during k_wb2: phase extends by exactly 5 cycles; with STRETCH_EN=0 there is no extension.
- D=2, WRITE 1 with sda_in forced 0: rsp_arb_lost=1, scl_out=sda_out=1, bus_active=0, next START accepted.
- STOP in k_idle and op=6 in k_hold: cmd_error pulses; outputs unchanged. A legal STOP then ends with scl=sda=1 and bus_active=0.
- Reset asserted mid-k_rs2 with D=0xFFFF: outputs released in the same cycle (asynchronous); after release, START is accepted.

Source files
------------

// File: rtl/i2c_bit_engine_pkg.sv
// Shared definitions for the bit-level I2C master engine: phase states,
// command op codes and the command legality rule.
package i2c_bit_engine_pkg;

    typedef enum logic [3:0] {
        k_idle   = 4'd0,
        k_hold   = 4'd1,
        k_start1 = 4'd2,
        k_start2 = 4'd3,
        k_rs1    = 4'd4,
        k_rs2    = 4'd5,
        k_sp1    = 4'd6,
        k_sp2    = 4'd7,
        k_sp3    = 4'd8,
        k_wb1    = 4'd9,
        k_wb2    = 4'd10,
        k_rb1    = 4'd11,
        k_rb2    = 4'd12
    } state_t;

    localparam logic [2:0] k_op_start  = 3'd0;
    localparam logic [2:0] k_op_rstart = 3'd1;
    localparam logic [2:0] k_op_stop   = 3'd2;
    localparam logic [2:0] k_op_write  = 3'd3;
    localparam logic [2:0] k_op_read   = 3'd4;

    // START only from a free bus; every other op needs the bus already owned.
    // Codes 5..7 are never legal.
    function automatic logic cmd_legal(input state_t st, input logic [2:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            k_op_start:  ok = (st == k_idle);
            k_op_rstart,
            k_op_stop,
            k_op_write,
            k_op_read:   ok = (st == k_hold);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/i2c_bit_engine_phase_timer.sv
// Half-period phase timer: counts 0..D for each phase, holds while a
// released SCL is being stretched low by a slave, and flags the last cycle.
module i2c_bit_engine_phase_timer #(
    parameter int CTR_WIDTH  = 16,
    parameter bit STRETCH_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CTR_WIDTH-1:0] divisor,
    input  logic                 run,
    input  logic                 scl_released,
    input  logic                 scl_in,
    output logic                 phase_done
);

    localparam logic [CTR_WIDTH-1:0] k_one = {{(CTR_WIDTH-1){1'b0}}, 1'b1};

    logic [CTR_WIDTH-1:0] ctr_r;
    logic [CTR_WIDTH-1:0] div_r;
    logic                 freeze_s;

    // Stretch freeze and end-of-phase detection.
    always_comb begin
        freeze_s   = 1'b0;
        phase_done = 1'b0;
        if (STRETCH_EN && scl_released && !scl_in) begin
            freeze_s = 1'b1;
        end else begin
            freeze_s = 1'b0;
        end
        if (run && !freeze_s && (ctr_r == div_r)) begin
            phase_done = 1'b1;
        end else begin
            phase_done = 1'b0;
        end
    end

    // Divisor latch on accept and phase counter advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctr_r <= '0;
            div_r <= '0;
        end else if (load) begin
            div_r <= divisor;
            ctr_r <= '0;
        end else if (!run || freeze_s) begin
            ctr_r <= ctr_r;
        end else if (ctr_r == div_r) begin
            ctr_r <= '0;
        end else begin
            ctr_r <= ctr_r + k_one;
        end
    end

endmodule

// File: rtl/i2c_bit_engine.sv
// Bit-level I2C master engine: turns START / RSTART / STOP / WRITE / READ
// commands into timed SCL/SDA phase sequences, with clock stretching,
// arbitration-loss detection and illegal-command rejection.
module i2c_bit_engine
    import i2c_bit_engine_pkg::*;
#(
    parameter int CTR_WIDTH  = 16,
    parameter bit STRETCH_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CTR_WIDTH-1:0] dbl_clock_divisor,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic                 cmd_bit,
    output logic                 rsp_valid,
    output logic                 rsp_bit,
    output logic                 rsp_arb_lost,
    output logic                 cmd_error,
    output logic                 bus_active,
    input  logic                 scl_in,
    input  logic                 sda_in,
    output logic                 scl_out,
    output logic                 sda_out
);

    state_t state_r;
    logic   accept_s;
    logic   legal_s;
    logic   run_s;
    logic   phase_done_s;

    assign accept_s = cmd_valid && cmd_ready;
    assign legal_s  = cmd_legal(state_r, cmd_op);
    assign run_s    = (state_r != k_idle) && (state_r != k_hold);

    i2c_bit_engine_phase_timer #(
        .CTR_WIDTH  (CTR_WIDTH),
        .STRETCH_EN (STRETCH_EN)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .load         (accept_s && legal_s),
        .divisor      (dbl_clock_divisor),
        .run          (run_s),
        .scl_released (scl_out),
        .scl_in       (scl_in),
        .phase_done   (phase_done_s)
    );

    // Command sequencer with registered line drives and response pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= k_idle;
            scl_out      <= 1'b1;
            sda_out      <= 1'b1;
            cmd_ready    <= 1'b1;
            bus_active   <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_bit      <= 1'b0;
            rsp_arb_lost <= 1'b0;
            cmd_error    <= 1'b0;
        end else begin
            rsp_valid    <= 1'b0;
            rsp_bit      <= 1'b0;
            rsp_arb_lost <= 1'b0;
            cmd_error    <= 1'b0;
            case (state_r)
                k_idle, k_hold: begin
                    if (accept_s && !legal_s) begin
                        cmd_error <= 1'b1;
                    end else if (accept_s) begin
                        cmd_ready <= 1'b0;
                        case (cmd_op)
                            k_op_start: begin
                                state_r    <= k_start1;
                                scl_out    <= 1'b1;
                                sda_out    <= 1'b0;
                                bus_active <= 1'b1;
                            end
                            k_op_rstart: begin
                                state_r <= k_rs1;
                                scl_out <= 1'b0;
                                sda_out <= 1'b1;
                            end
                            k_op_stop: begin
                                state_r <= k_sp1;
                                scl_out <= 1'b0;
                                sda_out <= 1'b0;
                            end
                            k_op_write: begin
                                state_r <= k_wb1;
                                scl_out <= 1'b0;
                                sda_out <= cmd_bit;
                            end
                            k_op_read: begin
                                state_r <= k_rb1;
                                scl_out <= 1'b0;
                                sda_out <= 1'b1;
                            end
                            default: begin
                                cmd_ready <= 1'b1;
                                cmd_error <= 1'b1;
                            end
                        endcase
                    end else begin
                        state_r <= state_r;
                    end
                end
                k_start1: if (phase_done_s) begin
                    state_r <= k_start2;
                    scl_out <= 1'b0;
                    sda_out <= 1'b0;
                end
                k_start2: if (phase_done_s) begin
                    state_r   <= k_hold;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b1;
                end
                k_rs1: if (phase_done_s) begin
                    state_r <= k_rs2;
                    scl_out <= 1'b1;
                    sda_out <= 1'b1;
                end
                k_rs2: if (phase_done_s) begin
                    state_r <= k_start1;
                    scl_out <= 1'b1;
                    sda_out <= 1'b0;
                end
                k_sp1: if (phase_done_s) begin
                    state_r <= k_sp2;
                    scl_out <= 1'b1;
                    sda_out <= 1'b0;
                end
                k_sp2: if (phase_done_s) begin
                    state_r <= k_sp3;
                    scl_out <= 1'b1;
                    sda_out <= 1'b1;
                end
                k_sp3: if (phase_done_s) begin
                    // Someone else holding SDA low after our STOP means we lost.
                    state_r      <= k_idle;
                    cmd_ready    <= 1'b1;
                    bus_active   <= 1'b0;
                    rsp_valid    <= 1'b1;
                    rsp_arb_lost <= !sda_in;
                end
                k_wb1: if (phase_done_s) begin
                    state_r <= k_wb2;
                    scl_out <= 1'b1;
                end
                k_wb2: if (phase_done_s) begin
                    // sda_out still carries the bit being written.
                    rsp_valid <= 1'b1;
                    rsp_bit   <= sda_in;
                    cmd_ready <= 1'b1;
                    if (sda_out && !sda_in) begin
                        state_r      <= k_idle;
                        rsp_arb_lost <= 1'b1;
                        bus_active   <= 1'b0;
                        scl_out      <= 1'b1;
                        sda_out      <= 1'b1;
                    end else begin
                        state_r <= k_hold;
                        scl_out <= 1'b0;
                    end
                end
                k_rb1: if (phase_done_s) begin
                    state_r <= k_rb2;
                    scl_out <= 1'b1;
                end
                k_rb2: if (phase_done_s) begin
                    state_r   <= k_hold;
                    scl_out   <= 1'b0;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_bit   <= sda_in;
                end
                default: begin
                    state_r    <= k_idle;
                    scl_out    <= 1'b1;
                    sda_out    <= 1'b1;
                    cmd_ready  <= 1'b1;
                    bus_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bit_engine.sv
// Directed self-checking bench for i2c_bit_engine. dut drives the main
// scenarios with stretching enabled; dut2 has stretching disabled and is
// only commanded in the stretch scenario.
module tb_i2c_bit_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] dbl_clock_divisor = 16'd0;
    logic        cmd_valid = 1'b0;
    logic        cmd_valid2 = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic        cmd_bit = 1'b0;
    logic        scl_in = 1'b1;
    logic        sda_in = 1'b1;

    logic cmd_ready, rsp_valid, rsp_bit, rsp_arb_lost, cmd_error, bus_active, scl_out, sda_out;
    logic cmd_ready2, rsp_valid2, rsp_bit2, rsp_arb_lost2, cmd_error2, bus_active2, scl_out2, sda_out2;

    int checks = 0;
    int errors = 0;

    i2c_bit_engine #(.CTR_WIDTH(16), .STRETCH_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .dbl_clock_divisor(dbl_clock_divisor),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_bit(cmd_bit),
        .rsp_valid(rsp_valid), .rsp_bit(rsp_bit), .rsp_arb_lost(rsp_arb_lost),
        .cmd_error(cmd_error), .bus_active(bus_active),
        .scl_in(scl_in), .sda_in(sda_in), .scl_out(scl_out), .sda_out(sda_out)
    );

    i2c_bit_engine #(.CTR_WIDTH(16), .STRETCH_EN(1'b0)) dut2 (
        .clk(clk), .reset(reset), .dbl_clock_divisor(dbl_clock_divisor),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_op(cmd_op), .cmd_bit(cmd_bit),
        .rsp_valid(rsp_valid2), .rsp_bit(rsp_bit2), .rsp_arb_lost(rsp_arb_lost2),
        .cmd_error(cmd_error2), .bus_active(bus_active2),
        .scl_in(scl_in), .sda_in(sda_in), .scl_out(scl_out2), .sda_out(sda_out2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command for exactly one cycle to the selected engine.
    task automatic issue(input logic [2:0] op, input logic b, input bit sel2);
        cmd_op  = op;
        cmd_bit = b;
        if (sel2) cmd_valid2 = 1'b1;
        else      cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
        cmd_valid2 = 1'b0;
    endtask

    // Cycles after the accept edge until rsp_valid is seen (limit on timeout).
    task automatic wait_rsp(input bit sel2, input int limit, output int n);
        n = 0;
        while (!(sel2 ? rsp_valid2 : rsp_valid) && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({scl_out, sda_out, cmd_ready, bus_active, rsp_valid, rsp_bit, rsp_arb_lost, cmd_error} !== 8'b1110_0000) begin
            errors++;
            $display("FAIL reset_dut: got %b expected 11100000",
                     {scl_out, sda_out, cmd_ready, bus_active, rsp_valid, rsp_bit, rsp_arb_lost, cmd_error});
        end
        checks++;
        if ({scl_out2, sda_out2, cmd_ready2, bus_active2, rsp_valid2, rsp_bit2, rsp_arb_lost2, cmd_error2} !== 8'b1110_0000) begin
            errors++;
            $display("FAIL reset_dut2: got %b expected 11100000",
                     {scl_out2, sda_out2, cmd_ready2, bus_active2, rsp_valid2, rsp_bit2, rsp_arb_lost2, cmd_error2});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_start();
        logic exp_scl;
        dbl_clock_divisor = 16'd3;
        issue(3'd0, 1'b0, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            exp_scl = (c >= 5) ? 1'b0 : 1'b1;
            checks++;
            if ({sda_out, scl_out, rsp_valid} !== {1'b0, exp_scl, 1'b0}) begin
                errors++;
                $display("FAIL start_cycle%0d: sda/scl/rsp got %b expected %b",
                         c, {sda_out, scl_out, rsp_valid}, {1'b0, exp_scl, 1'b0});
            end
            tick();
        end
        checks++;
        if ({rsp_valid, bus_active, cmd_ready, rsp_arb_lost} !== 4'b1110) begin
            errors++;
            $display("FAIL start_done: rsp/bus/ready/arb got %b expected 1110",
                     {rsp_valid, bus_active, cmd_ready, rsp_arb_lost});
        end
    endtask

    task automatic test_write_read();
        int n;
        tick();
        dbl_clock_divisor = 16'd3;
        sda_in = 1'b1;
        issue(3'd3, 1'b1, 1'b0);
        dbl_clock_divisor = 16'd0;   // must not affect the running command
        wait_rsp(1'b0, 50, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL write_latency: got %0d expected 8", n);
        end
        checks++;
        if ({rsp_bit, rsp_arb_lost, cmd_ready, scl_out} !== 4'b1010) begin
            errors++;
            $display("FAIL write_rsp: bit/arb/ready/scl got %b expected 1010",
                     {rsp_bit, rsp_arb_lost, cmd_ready, scl_out});
        end
        // back-to-back READ accepted on the response cycle
        dbl_clock_divisor = 16'd3;
        sda_in = 1'b0;
        issue(3'd4, 1'b0, 1'b0);
        wait_rsp(1'b0, 50, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL read_latency: got %0d expected 8", n);
        end
        checks++;
        if ({rsp_bit, rsp_arb_lost, sda_out, scl_out, bus_active} !== 5'b00101) begin
            errors++;
            $display("FAIL read_rsp: bit/arb/sda/scl/bus got %b expected 00101",
                     {rsp_bit, rsp_arb_lost, sda_out, scl_out, bus_active});
        end
        sda_in = 1'b1;
    endtask

    // WRITE 0 with SCL held low for 5 cycles once the engine releases it.
    task automatic stretch_write(input bit sel2, output int n);
        int k;
        issue(3'd3, 1'b0, sel2);
        n = 0;
        while (((sel2 ? scl_out2 : scl_out) == 1'b0) && n < 50) begin
            tick();
            n++;
        end
        scl_in = 1'b0;
        k = 0;
        while (k < 5 && !(sel2 ? rsp_valid2 : rsp_valid)) begin
            tick();
            n++;
            k++;
        end
        scl_in = 1'b1;
        while (!(sel2 ? rsp_valid2 : rsp_valid) && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic test_stretch();
        int n;
        tick();
        dbl_clock_divisor = 16'd1;
        stretch_write(1'b0, n);
        checks++;
        if (n !== 9) begin
            errors++;
            $display("FAIL stretch_en1_latency: got %0d expected 9", n);
        end
        checks++;
        if ({rsp_bit, rsp_arb_lost} !== 2'b10) begin
            errors++;
            $display("FAIL stretch_en1_rsp: bit/arb got %b expected 10", {rsp_bit, rsp_arb_lost});
        end
        tick();
        issue(3'd0, 1'b0, 1'b1);
        wait_rsp(1'b1, 50, n);
        checks++;
        if (n !== 4 || bus_active2 !== 1'b1) begin
            errors++;
            $display("FAIL stretch_en0_start: latency %0d bus %b expected 4 1", n, bus_active2);
        end
        tick();
        stretch_write(1'b1, n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL stretch_en0_latency: got %0d expected 4", n);
        end
    endtask

    task automatic test_arb_lost();
        int n;
        tick();
        dbl_clock_divisor = 16'd2;
        sda_in = 1'b0;
        issue(3'd3, 1'b1, 1'b0);
        wait_rsp(1'b0, 50, n);
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL arb_latency: got %0d expected 6", n);
        end
        checks++;
        if ({rsp_arb_lost, rsp_bit, scl_out, sda_out, bus_active, cmd_ready} !== 6'b101101) begin
            errors++;
            $display("FAIL arb_state: arb/bit/scl/sda/bus/ready got %b expected 101101",
                     {rsp_arb_lost, rsp_bit, scl_out, sda_out, bus_active, cmd_ready});
        end
        sda_in = 1'b1;
        issue(3'd0, 1'b0, 1'b0);
        checks++;
        if ({cmd_error, scl_out, sda_out, bus_active} !== 4'b0101) begin
            errors++;
            $display("FAIL arb_restart: err/scl/sda/bus got %b expected 0101",
                     {cmd_error, scl_out, sda_out, bus_active});
        end
        wait_rsp(1'b0, 50, n);
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL arb_restart_latency: got %0d expected 6", n);
        end
    endtask

    task automatic test_illegal();
        int n;
        tick();
        dbl_clock_divisor = 16'd0;
        issue(3'd6, 1'b0, 1'b0);
        checks++;
        if ({cmd_error, rsp_valid, scl_out, sda_out, bus_active, cmd_ready} !== 6'b100011) begin
            errors++;
            $display("FAIL illegal_op6: err/rsp/scl/sda/bus/ready got %b expected 100011",
                     {cmd_error, rsp_valid, scl_out, sda_out, bus_active, cmd_ready});
        end
        tick();
        checks++;
        if (cmd_error !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse: cmd_error got %b expected 0", cmd_error);
        end
        issue(3'd2, 1'b0, 1'b0);
        wait_rsp(1'b0, 50, n);
        checks++;
        if (n !== 3 || {scl_out, sda_out, bus_active, rsp_arb_lost} !== 4'b1100) begin
            errors++;
            $display("FAIL stop_legal: latency %0d scl/sda/bus/arb %b expected 3 1100",
                     n, {scl_out, sda_out, bus_active, rsp_arb_lost});
        end
        tick();
        issue(3'd2, 1'b0, 1'b0);
        checks++;
        if ({cmd_error, rsp_valid, scl_out, sda_out, bus_active, cmd_ready} !== 6'b101101) begin
            errors++;
            $display("FAIL stop_in_idle: err/rsp/scl/sda/bus/ready got %b expected 101101",
                     {cmd_error, rsp_valid, scl_out, sda_out, bus_active, cmd_ready});
        end
    endtask

    task automatic test_reset_mid_rs2();
        int n;
        tick();
        dbl_clock_divisor = 16'd0;
        issue(3'd0, 1'b0, 1'b0);
        wait_rsp(1'b0, 50, n);
        tick();
        dbl_clock_divisor = 16'hFFFF;
        issue(3'd1, 1'b0, 1'b0);
        n = 0;
        while (scl_out == 1'b0 && n < 70000) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 65536 || {cmd_ready, bus_active, sda_out} !== 3'b011) begin
            errors++;
            $display("FAIL rs1_length: cycles %0d ready/bus/sda %b expected 65536 011",
                     n, {cmd_ready, bus_active, sda_out});
        end
        tick();
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({scl_out, sda_out, cmd_ready, bus_active, rsp_valid, cmd_error} !== 6'b111000) begin
            errors++;
            $display("FAIL async_reset: scl/sda/ready/bus/rsp/err got %b expected 111000",
                     {scl_out, sda_out, cmd_ready, bus_active, rsp_valid, cmd_error});
        end
        tick();
        reset = 1'b0;
        dbl_clock_divisor = 16'd0;
        tick();
        issue(3'd0, 1'b0, 1'b0);
        checks++;
        if ({cmd_error, sda_out, scl_out} !== 3'b001) begin
            errors++;
            $display("FAIL post_reset_start: err/sda/scl got %b expected 001",
                     {cmd_error, sda_out, scl_out});
        end
        wait_rsp(1'b0, 50, n);
        checks++;
        if (n !== 2 || bus_active !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_done: latency %0d bus %b expected 2 1", n, bus_active);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_write_read();
        test_stretch();
        test_arb_lost();
        test_illegal();
        test_reset_mid_rs2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
